fpu_req_master: RTL and testbench
=================================

// Module: fpu_req_master
// PURPOSE
//  Requester side of the FPU command handshake: buffers commands from the core, drives fpu ready/x1/x2/y/operation/in_data,
//  holds each command until fpu valid, returns out_data/cond to the core.
//  Sits between core issue stage and fpu; opcode-agnostic (6-bit operation passed through untouched).
//  Adds response backpressure and a watchdog so a hung FPU cannot stall the core forever.
// PARAMETERS
//  DEPTH    4     command FIFO entries; power of 2, >=2
//  TIMEOUT  1024  max cycles in WAIT before abort; 0 disables watchdog
// PORTS
//  clk           in   1   clock, all flops on posedge
//  rstn          in   1   asynchronous active-low reset
//  cmd_valid     in   1   core offers a command
//  cmd_ready     out  1   FIFO not full; push on cmd_valid&&cmd_ready
//  cmd_op        in   6   fpu operation code
//  cmd_x1        in   5   source register 1
//  cmd_x2        in   5   source register 2
//  cmd_y         in   5   destination register
//  cmd_data      in   32  immediate / in_data payload
//  rsp_valid     out  1   response available
//  rsp_ready     in   1   core consumes response on rsp_valid&&rsp_ready
//  rsp_data      out  32  captured fpu out_data (0 on timeout)
//  rsp_cond      out  1   captured fpu cond (0 on timeout)
//  rsp_timeout   out  1   response is a watchdog abort
//  fpu_ready     out  1   request strobe to fpu, held high until fpu_valid
//  fpu_valid     in   1   fpu completion
//  fpu_operation out  6   registered command fields, stable while fpu_ready=1
//  fpu_x1        out  5
//  fpu_x2        out  5
//  fpu_y         out  5
//  fpu_in_data   out  32
//  fpu_out_data  in   32  fpu result
//  fpu_cond      in   1   fpu condition flag
//  busy          out  1   FIFO non-empty or state!=IDLE
// BEHAVIOUR
//  Reset (rstn=0, async): state IDLE, FIFO empty, fpu_ready=0, all fpu_* fields=0, rsp_valid/rsp_data/rsp_cond/rsp_timeout=0,
//   busy=0, cmd_ready=1; pushes ignored while rstn=0.
//   Reset mid-operation: fpu_ready drops immediately; in-flight and queued commands discarded, no response.
//  FIFO: cmd_ready = !full. Full-with-pop-same-cycle still refuses push. Order strictly preserved.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: if FIFO non-empty: pop head into fpu_* regs, fpu_ready<=1, clear watchdog, -> WAIT.
//   WAIT: fpu_* fields and fpu_ready held constant.
//    fpu_valid=1 at edge: fpu_ready<=0, rsp_data<=fpu_out_data, rsp_cond<=fpu_cond, rsp_timeout<=0, rsp_valid<=1, -> RESP.
//    else if TIMEOUT!=0 and count==TIMEOUT-1: fpu_ready<=0, rsp_data<=0, rsp_cond<=0, rsp_timeout<=1, rsp_valid<=1, -> RESP.
//    else count++ (width $clog2(TIMEOUT+1), never wraps).
//   RESP: rsp_* stable while rsp_valid&&!rsp_ready. On rsp_ready: rsp_valid<=0, -> IDLE.
//  fpu_valid outside WAIT (late/stray) ignored, no state change.
//  After valid, fpu_* fields hold last values; only fpu_ready meaningful.
//  Latency: cmd pushed at edge N into empty idle block -> fpu_ready=1 after edge N+1.
//   fpu_valid sampled at edge M -> fpu_ready=0 and rsp_valid=1 after M.
//   Min fpu_ready low gap between commands = 2 cycles (RESP + IDLE).
//  One outstanding fpu request at a time; next issue never before response consumed.
// STRUCTURE
//  Package fpu_pkg: fpu_cmd_t packed struct {op[5:0], x1[4:0], x2[4:0], y[4:0], data[31:0]};
//   req_state_t enum {IDLE, WAIT, RESP}; OP_FLOAD=6'b111110, OP_FUNARY=6'b110001 for benches.
//  Sub-module fpu_cmd_fifo: sync FIFO of fpu_cmd_t, DEPTH param, push/pop/full/empty, async active-low reset.
//  Top: FSM, watchdog counter, response registers.
// TESTING
//  1 Push op=111110 y=0 data=3f000000; model fpu valid 3 cycles after ready, out_data=3f000000
//    -> fpu_y=0/in_data held; rsp_data=3f000000; rsp_timeout=0; fpu_ready low next cycle.
//  2 Push 4 loads (3f000000, 3e624dd2, be999999, 3fe089a0 to y=0..3) back-to-back; rsp_ready=1
//    -> issued in order; fpu_ready low >=2 cycles between; 4 responses in order.
//  3 Fpu stalled; DEPTH+1 pushes -> cmd_ready=0 after DEPTH+1 accepted (1 in WAIT + DEPTH queued);
//    release -> all delivered, none lost/duplicated.
//  4 rsp_ready=0 for 10 cycles after response -> rsp_* stable; no second fpu_ready; issue resumes 2 edges after consume.
//  5 TIMEOUT=16, fpu never valid -> rsp_valid with rsp_timeout=1, rsp_data=0 exactly 16 cycles after issue;
//    fpu_ready=0; stray fpu_valid later ignored.
//  6 Assert rstn=0 mid-WAIT with 2 queued -> fpu_ready=0 at once; after release busy=0, cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FPU requester slice.
//   fpu_cmd_t    : one queued command (operation, two sources, destination, payload)
//   req_state_t  : requester FSM states
//   OP_FLOAD / OP_FUNARY : sample operation codes used by benches; the
//                  requester itself never decodes the operation field.
package fpu_pkg;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  x1;
        logic [4:0]  x2;
        logic [4:0]  y;
        logic [31:0] data;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } req_state_t;

    localparam logic [5:0] OP_FLOAD  = 6'b111110;
    localparam logic [5:0] OP_FUNARY = 6'b110001;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO holding fpu_cmd_t entries.
// Ports:
//   clk, rstn   : clock and asynchronous active-low reset
//   push, din   : write request and entry (ignored while full)
//   pop, dout   : read request and current head (ignored while empty)
//   full, empty : occupancy flags, both derived from registered pointers
module fpu_cmd_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  fpu_cmd_t din,
    input  logic     pop,
    output fpu_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fpu_cmd_t    mem_q [DEPTH];
    fpu_cmd_t    mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Full looks only at registered pointers, so a pop in the same cycle
    // does not open a slot for a push.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fpu_req_master.sv
// Requester side of the FPU command handshake.
// Commands from the core are queued, issued one at a time to the FPU with
// fpu_ready held high until fpu_valid, and the result is returned to the core
// through a valid/ready response port. A watchdog aborts a request that the
// FPU never completes.
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*     : command input from the core
//   rsp_valid/rsp_ready, rsp_*     : response output to the core
//   fpu_ready, fpu_operation..in_data : registered request to the FPU
//   fpu_valid, fpu_out_data, fpu_cond : completion from the FPU
//   busy                           : work queued or in flight
module fpu_req_master
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [4:0]  cmd_x1,
    input  logic [4:0]  cmd_x2,
    input  logic [4:0]  cmd_y,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_cond,
    output logic        rsp_timeout,
    output logic        fpu_ready,
    input  logic        fpu_valid,
    output logic [5:0]  fpu_operation,
    output logic [4:0]  fpu_x1,
    output logic [4:0]  fpu_x2,
    output logic [4:0]  fpu_y,
    output logic [31:0] fpu_in_data,
    input  logic [31:0] fpu_out_data,
    input  logic        fpu_cond,
    output logic        busy
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    req_state_t    state_q, state_d;
    fpu_cmd_t      req_q, req_d;
    logic          fpu_ready_q, fpu_ready_d;
    logic [CW-1:0] count_q, count_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_cond_q, rsp_cond_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    fpu_cmd_t      cmd_in;
    fpu_cmd_t      fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    assign cmd_in    = {cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data};
    assign cmd_ready = !fifo_full;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: only one request is outstanding, and a new one is
    // issued only after the previous response has been consumed.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        fpu_ready_d   = fpu_ready_q;
        count_d       = count_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_cond_d    = rsp_cond_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    req_d       = fifo_head;
                    fpu_ready_d = 1'b1;
                    count_d     = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (fpu_valid) begin
                    fpu_ready_d   = 1'b0;
                    rsp_data_d    = fpu_out_data;
                    rsp_cond_d    = fpu_cond;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if ((TIMEOUT != 0) && (count_q == CNT_LAST)) begin
                    fpu_ready_d   = 1'b0;
                    rsp_data_d    = '0;
                    rsp_cond_d    = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (count_q != CNT_MAX) begin
                    // Saturate so a disabled watchdog never wraps.
                    count_d = count_q + CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            req_q         <= '0;
            fpu_ready_q   <= 1'b0;
            count_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_cond_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            fpu_ready_q   <= fpu_ready_d;
            count_q       <= count_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_cond_q    <= rsp_cond_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign fpu_ready     = fpu_ready_q;
    assign fpu_operation = req_q.op;
    assign fpu_x1        = req_q.x1;
    assign fpu_x2        = req_q.x2;
    assign fpu_y         = req_q.y;
    assign fpu_in_data   = req_q.data;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_cond      = rsp_cond_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_req_master.sv
// Bench for fpu_req_master: a behavioural FPU answers each request after a
// fixed delay (or stalls on demand); accepted commands are scoreboarded as
// expected issues and expected responses and checked as the DUT produces them.
module tb_fpu_req_master;
    import fpu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_op;
    logic [4:0]  cmd_x1;
    logic [4:0]  cmd_x2;
    logic [4:0]  cmd_y;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_cond;
    logic        rsp_timeout;
    logic        fpu_ready;
    logic        fpu_valid;
    logic [5:0]  fpu_operation;
    logic [4:0]  fpu_x1;
    logic [4:0]  fpu_x2;
    logic [4:0]  fpu_y;
    logic [31:0] fpu_in_data;
    logic [31:0] fpu_out_data;
    logic        fpu_cond;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        cond;
        logic        timeout;
    } exp_rsp_t;

    typedef struct {
        fpu_cmd_t cmd;
        exp_rsp_t rsp;
    } vec_t;

    fpu_cmd_t issue_q[$];
    exp_rsp_t rsp_q[$];
    vec_t     vecs[4];

    int       total;
    int       bad;
    int       cyc;
    int       issue_cyc;
    int       low_gap;
    int       wait_cnt;
    int       fpu_delay;
    bit       have_fall;
    bit       prev_ready;
    bit       accepted;
    bit       stray_req;
    bit       fpu_stall;
    bit       expect_timeout;
    bit       ok;
    fpu_cmd_t cur_cmd;
    fpu_cmd_t pend_cmd;
    exp_rsp_t pend_rsp;
    fpu_cmd_t c;
    exp_rsp_t e;

    fpu_req_master #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x1        (cmd_x1),
        .cmd_x2        (cmd_x2),
        .cmd_y         (cmd_y),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_cond      (rsp_cond),
        .rsp_timeout   (rsp_timeout),
        .fpu_ready     (fpu_ready),
        .fpu_valid     (fpu_valid),
        .fpu_operation (fpu_operation),
        .fpu_x1        (fpu_x1),
        .fpu_x2        (fpu_x2),
        .fpu_y         (fpu_y),
        .fpu_in_data   (fpu_in_data),
        .fpu_out_data  (fpu_out_data),
        .fpu_cond      (fpu_cond),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Reference FPU behaviour: result = in_data ^ y, cond = x1[0]; a watchdog
    // abort returns zero data and cond with the timeout flag.
    function automatic exp_rsp_t model(input fpu_cmd_t cm, input bit tmo);
        exp_rsp_t r;
        if (tmo) begin
            r.data    = 32'd0;
            r.cond    = 1'b0;
            r.timeout = 1'b1;
        end else begin
            r.data    = cm.data ^ {27'd0, cm.y};
            r.cond    = cm.x1[0];
            r.timeout = 1'b0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: handshakes due at the coming edge are scored first, then the
    // issue monitor and the behavioural FPU run on the following falling edge.
    task automatic tick();
        exp_rsp_t ex;
        if (rstn) begin
            if (cmd_valid && cmd_ready) begin
                issue_q.push_back(pend_cmd);
                rsp_q.push_back(pend_rsp);
                accepted = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    ex = rsp_q.pop_front();
                    checkOutput("rsp_data", 64'(rsp_data), 64'(ex.data));
                    checkOutput("rsp_cond", 64'(rsp_cond), 64'(ex.cond));
                    checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(ex.timeout));
                end
            end
        end
        @(negedge clk);
        cyc++;

        if (fpu_ready && !prev_ready) begin
            if (issue_q.size() == 0) begin
                checkOutput("unexpected_issue", 64'(fpu_ready), 64'(0));
            end else begin
                cur_cmd = issue_q.pop_front();
                checkOutput("issue_fields",
                            64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}),
                            64'(cur_cmd));
            end
            if (have_fall) begin
                checkOutput("ready_gap_ge2", 64'(low_gap >= 2), 64'(1));
            end
            issue_cyc = cyc;
        end else if (fpu_ready) begin
            checkOutput("wait_fields_held",
                        64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}),
                        64'(cur_cmd));
        end
        if (!fpu_ready && prev_ready) begin
            have_fall = 1'b1;
            low_gap   = 0;
        end
        if (!fpu_ready) begin
            low_gap++;
        end
        prev_ready = fpu_ready;

        if (fpu_valid) begin
            fpu_valid = 1'b0;
            wait_cnt  = 0;
        end else if (stray_req) begin
            fpu_valid    = 1'b1;
            fpu_out_data = 32'hdeadbeef;
            fpu_cond     = 1'b1;
            stray_req    = 1'b0;
        end else if (fpu_ready) begin
            if (!fpu_stall) begin
                wait_cnt++;
                if (wait_cnt >= fpu_delay) begin
                    fpu_valid    = 1'b1;
                    fpu_out_data = fpu_in_data ^ {27'd0, fpu_y};
                    fpu_cond     = fpu_x1[0];
                end
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic applyStimulus(input fpu_cmd_t cm, input exp_rsp_t ex);
        cmd_valid = 1'b1;
        cmd_op    = cm.op;
        cmd_x1    = cm.x1;
        cmd_x2    = cm.x2;
        cmd_y     = cm.y;
        cmd_data  = cm.data;
        pend_cmd  = cm;
        pend_rsp  = ex;
        accepted  = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            tick();
        end
        cmd_valid = 1'b0;
        checkOutput("push_accepted", 64'(accepted), 64'(1));
    endtask

    task automatic waitRsp(input int limit);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (rsp_valid) ok = 1'b1;
        checkOutput("rsp_arrived", 64'(ok), 64'(1));
    endtask

    task automatic waitIssue(input int limit);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fpu_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (fpu_ready) ok = 1'b1;
        checkOutput("issue_arrived", 64'(ok), 64'(1));
    endtask

    task automatic waitIdle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy && !rsp_valid && issue_q.size() == 0 && rsp_q.size() == 0) break;
            tick();
        end
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_issue_q", 64'(issue_q.size()), 64'(0));
        checkOutput("idle_rsp_q", 64'(rsp_q.size()), 64'(0));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; issue_cyc = 0; low_gap = 0; wait_cnt = 0;
        fpu_delay = 3; have_fall = 0; prev_ready = 0; accepted = 0;
        stray_req = 0; fpu_stall = 0; expect_timeout = 0; ok = 0;
        cur_cmd = '0; pend_cmd = '0; pend_rsp = '0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x1 = '0; cmd_x2 = '0;
        cmd_y = '0; cmd_data = '0; rsp_ready = 1'b1;
        fpu_valid = 1'b0; fpu_out_data = '0; fpu_cond = 1'b0;

        vecs[0].cmd = {OP_FLOAD, 5'd1, 5'd0, 5'd0, 32'h3f000000};
        vecs[0].rsp = {32'h3f000000, 1'b1, 1'b0};
        vecs[1].cmd = {OP_FLOAD, 5'd2, 5'd0, 5'd1, 32'h3e624dd2};
        vecs[1].rsp = {32'h3e624dd3, 1'b0, 1'b0};
        vecs[2].cmd = {OP_FLOAD, 5'd3, 5'd0, 5'd2, 32'hbe999999};
        vecs[2].rsp = {32'hbe99999b, 1'b1, 1'b0};
        vecs[3].cmd = {OP_FLOAD, 5'd4, 5'd0, 5'd3, 32'h3fe089a0};
        vecs[3].rsp = {32'h3fe089a3, 1'b0, 1'b0};

        // Reset state, with a command offered during reset that must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 32'h12345678;
        repeat (3) @(negedge clk);
        checkOutput("reset_fpu_ready", 64'(fpu_ready), 64'(0));
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("reset_fpu_fields",
                    64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}), 64'(0));
        checkOutput("reset_rsp_fields", 64'({rsp_data, rsp_cond, rsp_timeout}), 64'(0));
        cmd_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checkOutput("reset_push_ignored", 64'(busy), 64'(0));

        // Test 1: single load, FPU answers 3 cycles after request.
        $display("[TB] test 1: single load");
        c = {OP_FLOAD, 5'd0, 5'd0, 5'd0, 32'h3f000000};
        applyStimulus(c, {32'h3f000000, 1'b0, 1'b0});
        tick();
        checkOutput("t1_issue_latency", 64'(fpu_ready), 64'(1));
        checkOutput("t1_fpu_y", 64'(fpu_y), 64'(0));
        checkOutput("t1_in_data", 64'(fpu_in_data), 64'(32'h3f000000));
        waitRsp(20);
        checkOutput("t1_rsp_latency", 64'(cyc - issue_cyc), 64'(3));
        checkOutput("t1_rsp_data", 64'(rsp_data), 64'(32'h3f000000));
        checkOutput("t1_rsp_timeout", 64'(rsp_timeout), 64'(0));
        checkOutput("t1_ready_dropped", 64'(fpu_ready), 64'(0));
        waitIdle(20);

        // Test 2: four loads back to back, table driven.
        $display("[TB] test 2: back-to-back loads");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].rsp);
        end
        waitIdle(200);

        // Test 3: stalled FPU, fill FIFO, refuse the next push, then drain.
        $display("[TB] test 3: fifo full under stall");
        fpu_stall = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = {OP_FUNARY, 5'(i), 5'(i + 7), 5'(i + 10), 32'h40000000 + 32'(i * 17)};
            applyStimulus(c, model(c, 1'b0));
        end
        checkOutput("t3_cmd_ready_full", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b1;
        cmd_data  = 32'hbadbad00;
        pend_cmd  = {OP_FUNARY, 5'd0, 5'd0, 5'd0, 32'hbadbad00};
        pend_rsp  = '0;
        accepted  = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checkOutput("t3_push_refused", 64'(accepted), 64'(0));
        fpu_stall = 1'b0;
        waitIdle(300);
        checkOutput("t3_cmd_ready_after", 64'(cmd_ready), 64'(1));

        // Test 4: response backpressure with a second command queued.
        $display("[TB] test 4: response backpressure");
        rsp_ready = 1'b0;
        c = {OP_FUNARY, 5'd5, 5'd6, 5'd9, 32'hcafe0001};
        e = model(c, 1'b0);
        applyStimulus(c, e);
        applyStimulus({OP_FLOAD, 5'd2, 5'd3, 5'd4, 32'h0badf00d},
                      model({OP_FLOAD, 5'd2, 5'd3, 5'd4, 32'h0badf00d}, 1'b0));
        waitRsp(30);
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_hold_valid", 64'(rsp_valid), 64'(1));
            checkOutput("t4_hold_data", 64'({rsp_data, rsp_cond, rsp_timeout}), 64'(e));
            checkOutput("t4_no_second_issue", 64'(fpu_ready), 64'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("t4_consumed", 64'(rsp_valid), 64'(0));
        checkOutput("t4_not_yet_issued", 64'(fpu_ready), 64'(0));
        tick();
        checkOutput("t4_resume", 64'(fpu_ready), 64'(1));
        waitIdle(100);

        // Test 5: watchdog abort, then a stray fpu_valid while idle.
        $display("[TB] test 5: watchdog");
        fpu_stall = 1'b1;
        c = {OP_FLOAD, 5'd1, 5'd1, 5'd7, 32'h3f800000};
        applyStimulus(c, model(c, 1'b1));
        waitIssue(5);
        waitRsp(40);
        checkOutput("t5_timeout_latency", 64'(cyc - issue_cyc), 64'(TIMEOUT));
        checkOutput("t5_rsp_timeout", 64'(rsp_timeout), 64'(1));
        checkOutput("t5_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("t5_ready_low", 64'(fpu_ready), 64'(0));
        tick();
        stray_req = 1'b1;
        repeat (3) tick();
        checkOutput("t5_stray_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("t5_stray_busy", 64'(busy), 64'(0));
        checkOutput("t5_stray_ready", 64'(fpu_ready), 64'(0));
        fpu_stall = 1'b0;
        waitIdle(20);

        // Test 6: reset while waiting with two commands queued.
        $display("[TB] test 6: reset mid-wait");
        fpu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c = {OP_FUNARY, 5'(i + 1), 5'd2, 5'(i), 32'h55550000 + 32'(i)};
            applyStimulus(c, model(c, 1'b0));
        end
        checkOutput("t6_in_wait", 64'(fpu_ready), 64'(1));
        rstn = 1'b0;
        #1;
        checkOutput("t6_ready_drop", 64'(fpu_ready), 64'(0));
        checkOutput("t6_busy_reset", 64'(busy), 64'(0));
        issue_q.delete();
        rsp_q.delete();
        fpu_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) tick();
        checkOutput("t6_busy", 64'(busy), 64'(0));
        checkOutput("t6_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("t6_no_rsp", 64'(rsp_valid), 64'(0));
        checkOutput("t6_no_issue", 64'(fpu_ready), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
